text_terminal_scroll: RTL and testbench
=======================================

Name: text_terminal_scroll

Overview:
Parametrised character-cell text terminal for the VGA path. It accepts a handshaked stream of character and command tokens, and keeps its own cursor with auto-advance, line wrap and newline. When output passes the bottom row it scrolls by one row, using a circular row pointer and an FSM that clears the new bottom row. A clear-screen command is also supported. The display side maps the raster counters to the stored glyph pixel, masks the active area, and shows the cursor as an underline.

Parameters:
COLS, 80, character columns per screen
ROWS, 60, character rows per screen
CHAR_W, 6, character code width; code 0 is blank
CTR_W, 11, width of the h_ctr and v_ctr raster counters
CURSOR_EN, 1, 1 = draw the cursor underline on glyph row 7 of the cursor cell

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_valid  in  1  token present
in_ready  out  1  block accepts a token this cycle
in_cmd  in  2  0 = PUT, 1 = NEWLINE, 2 = CLEAR, 3 = reserved (accepted, ignored)
in_char  in  CHAR_W  character code for PUT
h_ctr  in  CTR_W  horizontal pixel counter
v_ctr  in  CTR_W  vertical pixel counter
pixel_on  out  1  glyph pixel, 2-cycle latency from h_ctr/v_ctr
cursor_col  out  $clog2(COLS)  logical cursor column
cursor_row  out  $clog2(ROWS)  logical cursor row (0 = top of screen)
busy  out  1  clear or scroll FSM active

Behaviour:
- Storage: dual-port buffer of ROWS*COLS entries, CHAR_W bits each, with independent write and read ports. Physical address = phys_row*COLS + col, where phys_row = (logical_row + top_row) mod ROWS. The mod is done by compare-and-subtract; there is no divider.
- Reset: cursor_col, cursor_row and top_row go to 0; pixel_on goes to 0; the FSM enters CLEAR_ALL. Buffer contents are not reset directly; CLEAR_ALL overwrites them.
- Handshake: a token transfers when in_valid && in_ready. in_ready = (state == IDLE) && !rst.
- FSM states: IDLE, CLEAR_ALL, CLEAR_ROW. busy = (state != IDLE).
- CLEAR_ALL: writes 0 to one cell per cycle, addresses 0 to ROWS*COLS-1, then returns to IDLE. Duration is exactly ROWS*COLS cycles. Cursor and top_row stay 0.
- IDLE + PUT: writes in_char at the cursor cell in the same cycle, then cursor_col++.
  - If cursor_col was COLS-1: cursor_col <= 0 and a line advance is performed.
- IDLE + NEWLINE: cursor_col <= 0, then a line advance. Nothing is written to the buffer.
- IDLE + CLEAR: cursor and top_row reset to 0; the FSM enters CLEAR_ALL.
- Line advance:
  - If cursor_row < ROWS-1: cursor_row++ and the FSM stays in IDLE.
  - Otherwise: cursor_row holds at ROWS-1, top_row advances by 1 mod ROWS, and the FSM enters CLEAR_ROW.
- CLEAR_ROW: writes 0 to the COLS cells of the new bottom physical row (the old top_row value), then returns to IDLE. Duration is exactly COLS cycles.
- Display pipeline:
  - Stage 1 registers the cell code, glyph row/column = v_ctr[2:0]/h_ctr[2:0], an in-area flag and a cursor-hit flag.
  - Stage 2 registers the glyph bit as pixel_on.
  - In area: h_ctr[CTR_W-1:3] < COLS and v_ctr[CTR_W-1:3] < ROWS. Outside the area pixel_on = 0.
  - Display logical row = v_ctr>>3, mapped through top_row so scrolling is visible without copying.
  - Cursor: with CURSOR_EN=1, glyph row 7 of the cursor cell forces pixel_on = 1.
- Simultaneous events:
  - A display read of a cell written in the same cycle returns old data; a one-frame glitch is acceptable.
  - rst asserted mid-CLEAR_ROW or mid-CLEAR_ALL restarts CLEAR_ALL from address 0.

Decomposition:
- Shared package/const file: command encodings CMD_PUT/CMD_NEWLINE/CMD_CLEAR, FSM state encodings, GLYPH_SHIFT = 3, BLANK_CHAR = 0.
- One sub-module: terminal_glyph_rom. Input: code plus 3-bit row/column. Output: one registered pixel. It forms stage 2.

Test Plan:
- Params COLS=4, ROWS=3. Release rst -> busy=1 for exactly 12 cycles, in_ready=0 throughout, then in_ready=1 and cursor (0,0); all cells read 0.
- PUT codes 1,2,3,4 -> cursor goes (1,0),(2,0),(3,0), then wraps to (0,1); cell(0,3)=4, cell(1,0) untouched.
- From cursor row 2, NEWLINE -> top_row=1, busy=1 for exactly 4 cycles, cursor=(0,2). Raster row 0 now shows the old logical row 1; physical row 0 is all zeros.
- CLEAR with in_valid held and back-to-back PUTs -> no PUT accepted for 12 cycles; the first accepted PUT lands at (0,0).
- Raster sweep with h_ctr = 32..39 (outside the 4-column area) -> pixel_on=0. Cursor cell at glyph row 7 -> pixel_on=1, checked 2 cycles after the counters.
- Assert rst 2 cycles into CLEAR_ROW -> cursor/top_row=0 and CLEAR_ALL runs the full 12 cycles.

Source files
------------

// File: rtl/text_terminal_scroll_pkg.sv
// Shared encodings for the scrolling text terminal: command tokens,
// FSM states, glyph geometry and the built-in bit-pattern font.
package text_terminal_scroll_pkg;

  typedef enum logic [1:0] {
    CMD_PUT     = 2'd0,
    CMD_NEWLINE = 2'd1,
    CMD_CLEAR   = 2'd2,
    CMD_RSVD    = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CLEAR_ALL = 2'd1,
    ST_CLEAR_ROW = 2'd2
  } state_e;

  // Character cells are 8x8 pixels, so the cell index is the counter >> 3.
  localparam int GLYPH_SHIFT = 3;
  localparam int BLANK_CHAR  = 0;

  // Bit-pattern font: glyph column k lights when bit k of the code is set,
  // on glyph rows 0..6. Row 7 is left empty for the cursor underline.
  function automatic logic glyph_pixel(input logic [7:0] bits,
                                       input logic [2:0] row,
                                       input logic [2:0] col);
    return (row != 3'd7) && bits[col];
  endfunction

endpackage

// File: rtl/text_terminal_scroll_glyph_rom.sv
// Glyph lookup: code plus glyph row/column in, one registered pixel out.
// This register is the second stage of the display pipeline.
module terminal_glyph_rom
  import text_terminal_scroll_pkg::*;
#(
  parameter int CHAR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CHAR_W-1:0] i_code,
  input  logic [2:0]        i_row,
  input  logic [2:0]        i_col,
  output logic              o_pixel
);

  logic [7:0] w_bits;

  assign w_bits = 8'(i_code);

  // Register the font pixel for the requested code/row/column.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_pixel <= 1'b0;
    end else begin
      o_pixel <= glyph_pixel(w_bits, i_row, i_col);
    end
  end

endmodule

// File: rtl/text_terminal_scroll.sv
// Character-cell text terminal with cursor, wrap, newline, hardware scroll
// through a circular top-row pointer, clear-screen, and a two-stage raster
// read-out with underline cursor.
module text_terminal_scroll
  import text_terminal_scroll_pkg::*;
#(
  parameter int COLS      = 80,
  parameter int ROWS      = 60,
  parameter int CHAR_W    = 6,
  parameter int CTR_W     = 11,
  parameter int CURSOR_EN = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              in_cmd,
  input  logic [CHAR_W-1:0]       in_char,
  input  logic [CTR_W-1:0]        h_ctr,
  input  logic [CTR_W-1:0]        v_ctr,
  output logic                    pixel_on,
  output logic [$clog2(COLS)-1:0] cursor_col,
  output logic [$clog2(ROWS)-1:0] cursor_row,
  output logic                    busy
);

  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);
  localparam int CELLS = ROWS * COLS;
  localparam int AW    = $clog2(CELLS);
  localparam int TW    = CTR_W - GLYPH_SHIFT;

  localparam logic [CW-1:0]     COL_LAST  = CW'(COLS - 1);
  localparam logic [RW-1:0]     ROW_LAST  = RW'(ROWS - 1);
  localparam logic [AW-1:0]     CELL_LAST = AW'(CELLS - 1);
  localparam logic [AW-1:0]     RCNT_LAST = AW'(COLS - 1);
  localparam logic [RW:0]       ROWS_EXT  = (RW + 1)'(ROWS);
  localparam logic [TW-1:0]     COLS_T    = TW'(COLS);
  localparam logic [TW-1:0]     ROWS_T    = TW'(ROWS);
  localparam logic [CHAR_W-1:0] BLANK     = CHAR_W'(BLANK_CHAR);

  // Logical row to physical row through the circular pointer; the sum is
  // below 2*ROWS, so one compare-and-subtract is a complete modulo.
  function automatic logic [RW-1:0] phys_row(input logic [RW-1:0] lrow,
                                             input logic [RW-1:0] top);
    logic [RW:0] sum;
    sum = {1'b0, lrow} + {1'b0, top};
    sum = (sum >= ROWS_EXT) ? (sum - ROWS_EXT) : sum;
    return sum[RW-1:0];
  endfunction

  function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] prow,
                                              input logic [CW-1:0] col);
    return AW'(prow) * AW'(COLS) + AW'(col);
  endfunction

  // Character buffer: one write port (FSM/tokens), one read port (raster).
  logic [CHAR_W-1:0] r_mem [CELLS];

  state_e          r_state, w_state_nxt;
  logic [AW-1:0]   r_cnt, w_cnt_nxt;
  logic [CW-1:0]   r_col, w_col_nxt;
  logic [RW-1:0]   r_row, w_row_nxt;
  logic [RW-1:0]   r_top, w_top_nxt;
  logic [RW-1:0]   r_clr_row, w_clr_row_nxt;

  logic              w_fire;
  logic              w_advance;
  logic              w_we;
  logic [AW-1:0]     w_waddr;
  logic [CHAR_W-1:0] w_wdata;
  logic [RW-1:0]     w_cur_prow;

  assign in_ready   = (r_state == ST_IDLE) && !rst;
  assign busy       = (r_state != ST_IDLE);
  assign cursor_col = r_col;
  assign cursor_row = r_row;
  assign w_fire     = in_valid && in_ready;
  assign w_cur_prow = phys_row(r_row, r_top);

  // Next-state, cursor/scroll bookkeeping and buffer write request.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_col_nxt     = r_col;
    w_row_nxt     = r_row;
    w_top_nxt     = r_top;
    w_clr_row_nxt = r_clr_row;
    w_advance     = 1'b0;
    w_we          = 1'b0;
    w_waddr       = {AW{1'b0}};
    w_wdata       = BLANK;
    case (r_state)
      ST_IDLE: begin
        if (w_fire) begin
          case (cmd_e'(in_cmd))
            CMD_PUT: begin
              w_we    = 1'b1;
              w_waddr = cell_addr(w_cur_prow, r_col);
              w_wdata = in_char;
              if (r_col == COL_LAST) begin
                w_col_nxt = {CW{1'b0}};
                w_advance = 1'b1;
              end else begin
                w_col_nxt = r_col + 1'b1;
              end
            end
            CMD_NEWLINE: begin
              w_col_nxt = {CW{1'b0}};
              w_advance = 1'b1;
            end
            CMD_CLEAR: begin
              w_col_nxt   = {CW{1'b0}};
              w_row_nxt   = {RW{1'b0}};
              w_top_nxt   = {RW{1'b0}};
              w_cnt_nxt   = {AW{1'b0}};
              w_state_nxt = ST_CLEAR_ALL;
            end
            default: begin
              w_state_nxt = ST_IDLE;
            end
          endcase
          if (w_advance) begin
            if (r_row != ROW_LAST) begin
              w_row_nxt = r_row + 1'b1;
            end else begin
              // Old top row becomes the new bottom row and must be blanked.
              w_top_nxt     = (r_top == ROW_LAST) ? {RW{1'b0}} : (r_top + 1'b1);
              w_clr_row_nxt = r_top;
              w_cnt_nxt     = {AW{1'b0}};
              w_state_nxt   = ST_CLEAR_ROW;
            end
          end else begin
            w_row_nxt = w_row_nxt;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CLEAR_ALL: begin
        w_we    = 1'b1;
        w_waddr = r_cnt;
        if (r_cnt == CELL_LAST) begin
          w_cnt_nxt   = {AW{1'b0}};
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_CLEAR_ROW: begin
        w_we    = 1'b1;
        w_waddr = cell_addr(r_clr_row, CW'(r_cnt));
        if (r_cnt == RCNT_LAST) begin
          w_cnt_nxt   = {AW{1'b0}};
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Control state register; reset restarts a full-screen clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_CLEAR_ALL;
      r_cnt     <= {AW{1'b0}};
      r_col     <= {CW{1'b0}};
      r_row     <= {RW{1'b0}};
      r_top     <= {RW{1'b0}};
      r_clr_row <= {RW{1'b0}};
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_col     <= w_col_nxt;
      r_row     <= w_row_nxt;
      r_top     <= w_top_nxt;
      r_clr_row <= w_clr_row_nxt;
    end
  end

  // Buffer write port.
  always_ff @(posedge clk) begin
    if (!rst && w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  // Raster side: cell coordinates from the counters, mapped through top row.
  logic [TW-1:0] w_disp_row_t, w_disp_col_t;
  logic [RW-1:0] w_disp_row;
  logic [CW-1:0] w_disp_col;
  logic          w_in_area;
  logic          w_cursor_hit;
  logic [AW-1:0] w_rd_addr;

  assign w_disp_row_t = v_ctr[CTR_W-1:GLYPH_SHIFT];
  assign w_disp_col_t = h_ctr[CTR_W-1:GLYPH_SHIFT];
  assign w_in_area    = (w_disp_col_t < COLS_T) && (w_disp_row_t < ROWS_T);
  assign w_disp_row   = RW'(w_disp_row_t);
  assign w_disp_col   = CW'(w_disp_col_t);
  assign w_rd_addr    = w_in_area ? cell_addr(phys_row(w_disp_row, r_top), w_disp_col)
                                  : {AW{1'b0}};
  assign w_cursor_hit = (CURSOR_EN != 0) && w_in_area && (w_disp_row == r_row) &&
                        (w_disp_col == r_col) && (v_ctr[GLYPH_SHIFT-1:0] == 3'd7);

  logic [CHAR_W-1:0] r_rd_code;
  logic              r_area_s1, r_cur_s1, r_cur_s2;
  logic [2:0]        r_grow_s1, r_gcol_s1;
  logic [CHAR_W-1:0] w_rom_code;
  logic              w_glyph_pix;

  // Stage 1 buffer read; a same-cycle write is seen one read later.
  always_ff @(posedge clk) begin
    r_rd_code <= r_mem[w_rd_addr];
  end

  // Stage 1/2 side-band: glyph coordinates, area and cursor flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_area_s1 <= 1'b0;
      r_cur_s1  <= 1'b0;
      r_cur_s2  <= 1'b0;
      r_grow_s1 <= 3'd0;
      r_gcol_s1 <= 3'd0;
    end else begin
      r_area_s1 <= w_in_area;
      r_cur_s1  <= w_cursor_hit;
      r_cur_s2  <= r_cur_s1;
      r_grow_s1 <= v_ctr[GLYPH_SHIFT-1:0];
      r_gcol_s1 <= h_ctr[GLYPH_SHIFT-1:0];
    end
  end

  // Outside the active area the cell is treated as blank.
  assign w_rom_code = r_area_s1 ? r_rd_code : BLANK;

  terminal_glyph_rom #(
    .CHAR_W (CHAR_W)
  ) u_glyph_rom (
    .clk     (clk),
    .rst     (rst),
    .i_code  (w_rom_code),
    .i_row   (r_grow_s1),
    .i_col   (r_gcol_s1),
    .o_pixel (w_glyph_pix)
  );

  assign pixel_on = w_glyph_pix | r_cur_s2;

endmodule

// File: tb/tb_text_terminal_scroll.sv
// Scoreboard bench for text_terminal_scroll at COLS=4, ROWS=3: expected
// cursor positions and pixels are queued by the stimulus and popped by
// monitors when a token is accepted or a probed pixel emerges.
module tb_text_terminal_scroll;

  localparam int COLS   = 4;
  localparam int ROWS   = 3;
  localparam int CHAR_W = 6;
  localparam int CTR_W  = 11;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [1:0]        in_cmd = 2'd0;
  logic [CHAR_W-1:0] in_char = '0;
  logic [CTR_W-1:0]  h_ctr = '0;
  logic [CTR_W-1:0]  v_ctr = '0;
  logic              in_ready, pixel_on, busy;
  logic [1:0]        cursor_col, cursor_row;

  text_terminal_scroll #(
    .COLS(COLS), .ROWS(ROWS), .CHAR_W(CHAR_W), .CTR_W(CTR_W), .CURSOR_EN(1)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_cmd(in_cmd), .in_char(in_char), .h_ctr(h_ctr), .v_ctr(v_ctr),
    .pixel_on(pixel_on), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int q_tok_col[$];
  int q_tok_row[$];
  int q_pix_exp[$];
  int q_pix_id[$];
  int tok_n = 0;
  int pid = 0;
  logic probe_v = 1'b0;
  logic pv1 = 1'b0, pv2 = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Token monitor: after each accepted token compare the cursor.
  always @(posedge clk) begin
    if (in_valid && in_ready) begin
      #1;
      if (q_tok_col.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL tok%0d_unexpected accept with empty queue", tok_n);
      end else begin
        check($sformatf("tok%0d_col", tok_n), cursor_col, q_tok_col.pop_front());
        check($sformatf("tok%0d_row", tok_n), cursor_row, q_tok_row.pop_front());
      end
      tok_n++;
    end
  end

  // Pixel monitor: a probe's pixel appears two clock edges later.
  always @(posedge clk) begin
    pv1 <= probe_v;
    pv2 <= pv1;
  end

  always @(negedge clk) begin
    if (pv2) begin
      if (q_pix_exp.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pix_unexpected output with empty queue");
      end else begin
        check($sformatf("pix%0d", q_pix_id.pop_front()), pixel_on, q_pix_exp.pop_front());
      end
    end
  end

  task automatic send(input logic [1:0] cmd, input int ch, input int ec, input int er,
                      output int waited);
    q_tok_col.push_back(ec);
    q_tok_row.push_back(er);
    in_cmd   = cmd;
    in_char  = CHAR_W'(ch);
    in_valid = 1'b1;
    waited   = 0;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout cmd=%0d waited=%0d", cmd, waited);
      void'(q_tok_col.pop_back());
      void'(q_tok_row.pop_back());
      in_valid = 1'b0;
    end else begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic probe(input int h, input int v, input int exp);
    h_ctr   = CTR_W'(h);
    v_ctr   = CTR_W'(v);
    probe_v = 1'b1;
    q_pix_exp.push_back(exp);
    q_pix_id.push_back(pid);
    pid++;
    @(negedge clk);
  endtask

  task automatic probe_end();
    probe_v = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic measure_busy(input string name, input int exp);
    int n = 0;
    int rdy_seen = 0;
    #1;
    while (busy && n < 100) begin
      if (in_ready) rdy_seen = 1;
      n++;
      @(negedge clk);
      #1;
    end
    check({name, "_busy_len"}, n, exp);
    check({name, "_ready_low"}, rdy_seen, 0);
  endtask

  // Safety net in case the design stalls forever.
  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("rst_busy", busy, 1);
    check("rst_ready", in_ready, 0);
    check("rst_pixel", pixel_on, 0);
    check("rst_col", cursor_col, 0);
    check("rst_row", cursor_row, 0);

    // Power-up clear takes ROWS*COLS cycles.
    @(negedge clk);
    rst = 1'b0;
    measure_busy("init_clear", 12);
    check("init_ready", in_ready, 1);
    check("init_col", cursor_col, 0);
    check("init_row", cursor_row, 0);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        probe(c * 8 + c, r * 8, 0);
    probe(3, 7, 1);                 // cursor underline at (0,0)
    probe_end();

    // PUT 1..4 with wrap, then a reserved command that changes nothing.
    send(2'd0, 1, 1, 0, w);
    send(2'd0, 2, 2, 0, w);
    send(2'd0, 3, 3, 0, w);
    send(2'd0, 4, 0, 1, w);
    send(2'd3, 9, 0, 1, w);
    probe(24 + 2, 0, 1);            // cell(0,3)=4 -> bit 2
    probe(24 + 0, 0, 0);
    probe(0, 0, 1);                 // cell(0,0)=1 -> bit 0
    probe(1, 3, 0);
    probe(8 + 1, 0, 1);             // cell(0,1)=2 -> bit 1
    probe(16 + 0, 6, 1);            // cell(0,2)=3, glyph row 6
    probe(0, 8, 0);                 // cell(1,0) untouched
    probe(3, 15, 1);                // cursor at row 1 col 0
    probe(0, 7, 0);                 // old cursor cell, glyph row 7 empty
    probe_end();

    // Fill rows 1 and 2, then scroll on NEWLINE from the bottom row.
    send(2'd0, 5, 1, 1, w);
    send(2'd1, 0, 0, 2, w);
    measure_busy("nl_noscroll", 0);
    send(2'd0, 6, 1, 2, w);
    send(2'd1, 0, 0, 2, w);
    measure_busy("scroll", 4);
    probe(0, 0, 1);                 // raster row 0 = old row 1 (code 5)
    probe(2, 0, 1);
    probe(1, 0, 0);
    probe(1, 8, 1);                 // raster row 1 = old row 2 (code 6)
    probe(0, 8, 0);
    probe(24 + 2, 16, 0);           // new bottom row blanked
    probe(0, 16, 0);
    probe(8 + 1, 16, 0);
    probe(5, 23, 1);                // cursor at bottom row col 0
    probe(8 + 2, 15, 0);
    probe_end();

    // CLEAR then a held PUT: blocked for the whole clear, lands at (0,0).
    send(2'd2, 0, 0, 0, w);
    send(2'd0, 7, 1, 0, w);
    check("clear_block_cycles", w, 12);
    probe(0, 0, 1);
    probe(2, 0, 1);
    probe(3, 0, 0);
    probe(0, 8, 0);
    probe(1, 16, 0);
    probe_end();

    // Area masking and cursor underline timing.
    for (int h = 32; h < 40; h++) probe(h, 0, 0);
    for (int h = 32; h < 40; h++) probe(h, 7, 0);
    probe(0, 24, 0);
    probe(8, 7, 1);
    probe(15, 7, 1);
    probe(0, 0, 1);
    probe_end();

    // Reset two cycles into CLEAR_ROW restarts the full clear.
    send(2'd1, 0, 0, 1, w);
    send(2'd1, 0, 0, 2, w);
    send(2'd0, 2, 1, 2, w);
    send(2'd1, 0, 0, 2, w);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("midrow_rst_col", cursor_col, 0);
    check("midrow_rst_row", cursor_row, 0);
    check("midrow_rst_busy", busy, 1);
    @(negedge clk);
    rst = 1'b0;
    measure_busy("midrow_clear", 12);
    send(2'd0, 3, 1, 0, w);
    probe(0, 0, 1);
    probe(1, 0, 1);
    probe(1, 8, 0);
    probe(1, 16, 0);
    probe_end();

    repeat (3) @(negedge clk);
    check("tok_queue_drained", q_tok_col.size(), 0);
    check("pix_queue_drained", q_pix_exp.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
